// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: load-type encodings, register constants
// and the payload carried by the write-back stage register.
package mips_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned LT_W   = 3;
    localparam int unsigned OFF_W  = 2;

    localparam logic [LT_W-1:0] LW  = 3'b000;
    localparam logic [LT_W-1:0] LH  = 3'b001;
    localparam logic [LT_W-1:0] LHU = 3'b010;
    localparam logic [LT_W-1:0] LB  = 3'b011;
    localparam logic [LT_W-1:0] LBU = 3'b100;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // Link return address is two instructions past the jump (delay slot).
    localparam logic [XLEN-1:0] LINK_OFFSET = 32'd8;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  alu_result;
        logic [XLEN-1:0]  mem_data;
        logic [REG_W-1:0] write_reg;
        logic             reg_write;
        logic             mem_to_reg;
        logic             link;
        logic [LT_W-1:0]  load_type;
    } wb_payload_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Big-endian load alignment: picks the addressed byte/halfword out of the
// raw memory word and sign- or zero-extends it to a full register value.
module load_align
    import mips_pkg::*;
(
    input  logic [XLEN-1:0]  word_i,
    input  logic [OFF_W-1:0] offset_i,
    input  logic [LT_W-1:0]  load_type_i,
    output logic [XLEN-1:0]  result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Offset 0 addresses the most significant byte.
    always_comb begin
        byte_sel = word_i[31:24];
        unique case (offset_i)
            2'd0: byte_sel = word_i[31:24];
            2'd1: byte_sel = word_i[23:16];
            2'd2: byte_sel = word_i[15:8];
            2'd3: byte_sel = word_i[7:0];
            default: byte_sel = word_i[31:24];
        endcase
    end

    assign half_sel = offset_i[1] ? word_i[15:0] : word_i[31:16];

    // Undefined load-type codes fall back to a full-word load.
    always_comb begin
        result_o = word_i;
        case (load_type_i)
            LB:      result_o = {{24{byte_sel[7]}}, byte_sel};
            LBU:     result_o = {24'd0, byte_sel};
            LH:      result_o = {{16{half_sel[15]}}, half_sel};
            LHU:     result_o = {16'd0, half_sel};
            LW:      result_o = word_i;
            default: result_o = word_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: WB pipeline register, commit-value mux, register-file
// write port, one-cycle forward holding register and retired-instruction counter.
module wb_stage
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              MEMtoWB_valid,
    input  logic [XLEN-1:0]   MEMtoWB_PC,
    input  logic [XLEN-1:0]   MEMtoWB_ALUResult,
    input  logic [XLEN-1:0]   MEMtoWB_MemData,
    input  logic [REG_W-1:0]  MEMtoWB_WriteReg,
    input  logic              MEMtoWB_RegWrite,
    input  logic              MEMtoWB_MemtoReg,
    input  logic              MEMtoWB_Link,
    input  logic [LT_W-1:0]   MEMtoWB_LoadType,
    output logic [REG_W-1:0]  writeReg,
    output logic [XLEN-1:0]   writeData,
    output logic              RegWrite,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_reg,
    output logic [XLEN-1:0]   fwd_data,
    output logic [CNT_W-1:0]  retired
);

    wb_payload_t       in_pay;
    wb_payload_t       pay_q, pay_d;
    logic              valid_q, valid_d;
    logic              fwd_valid_q, fwd_valid_d;
    logic [REG_W-1:0]  fwd_reg_q, fwd_reg_d;
    logic [XLEN-1:0]   fwd_data_q, fwd_data_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   commit_data;
    logic              commit_we;

    assign in_pay = '{
        pc:         MEMtoWB_PC,
        alu_result: MEMtoWB_ALUResult,
        mem_data:   MEMtoWB_MemData,
        write_reg:  MEMtoWB_WriteReg,
        reg_write:  MEMtoWB_RegWrite,
        mem_to_reg: MEMtoWB_MemtoReg,
        link:       MEMtoWB_Link,
        load_type:  MEMtoWB_LoadType
    };

    load_align u_load_align (
        .word_i      (pay_q.mem_data),
        .offset_i    (pay_q.alu_result[OFF_W-1:0]),
        .load_type_i (pay_q.load_type),
        .result_o    (load_data)
    );

    // Commit mux and write enable; $0 is hardwired and never written.
    always_comb begin
        commit_data = pay_q.alu_result;
        if (pay_q.link) begin
            commit_data = pay_q.pc + LINK_OFFSET;
        end else if (pay_q.mem_to_reg) begin
            commit_data = load_data;
        end
    end

    assign commit_we = valid_q & pay_q.reg_write & (pay_q.write_reg != REG_ZERO);

    // Flush only kills the valid bit; payload contents are don't-care then.
    always_comb begin
        valid_d = valid_q;
        pay_d   = pay_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d = MEMtoWB_valid;
            pay_d   = in_pay;
        end
    end

    // Forward register tracks every edge, stalled or not.
    always_comb begin
        fwd_valid_d = commit_we;
        fwd_reg_d   = pay_q.write_reg;
        fwd_data_d  = commit_data;
    end

    // An instruction retires on the edge it leaves WB.
    always_comb begin
        retired_d = retired_q;
        if (valid_q && !stall) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q     <= 1'b0;
            pay_q       <= '0;
            fwd_valid_q <= 1'b0;
            fwd_reg_q   <= '0;
            fwd_data_q  <= '0;
            retired_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            pay_q       <= pay_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_reg_q   <= fwd_reg_d;
            fwd_data_q  <= fwd_data_d;
            retired_q   <= retired_d;
        end
    end

    assign writeReg  = pay_q.write_reg;
    assign writeData = commit_data;
    assign RegWrite  = commit_we;
    assign fwd_valid = fwd_valid_q;
    assign fwd_reg   = fwd_reg_q;
    assign fwd_data  = fwd_data_q;
    assign retired   = retired_q;

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage MIPS pipeline: registers MEM-stage results, selects and aligns the value to commit, and drives the register-file write port consumed by the decode stage (`writeReg`, `writeData`, `RegWrite`). It also holds the most recently committed write for one extra cycle, so decode can bypass a same-edge write/read collision, and it counts retired instructions.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  pipeline clock; all state changes on its rising edge.
- `rst`  in  1  reset; **synchronous, active-low**.
- `stall`  in  1  hold the WB register contents.
- `flush`  in  1  invalidate the incoming slot.
- `MEMtoWB_valid`  in  1  MEM slot holds a real instruction.
- `MEMtoWB_PC`  in  32  PC of the instruction.
- `MEMtoWB_ALUResult`  in  32  ALU result; its bits [1:0] are the load byte offset.
- `MEMtoWB_MemData`  in  32  raw word read from data memory.
- `MEMtoWB_WriteReg`  in  5  destination register.
- `MEMtoWB_RegWrite`  in  1  instruction writes a register.
- `MEMtoWB_MemtoReg`  in  1  select load data over ALU result.
- `MEMtoWB_Link`  in  1  jal/jalr; write PC+8.
- `MEMtoWB_LoadType`  in  3  load width/sign encoding (see Structure).
- `writeReg`  out  5  register-file write address.
- `writeData`  out  32  register-file write data.
- `RegWrite`  out  1  register-file write enable.
- `fwd_valid`  out  1  `fwd_reg`/`fwd_data` hold the previous cycle's committed write.
- `fwd_reg`  out  5  register written in the previous cycle.
- `fwd_data`  out  32  data written in the previous cycle.
- `retired`  out  `CNT_W`  count of valid instructions that left WB.

## Operation
- WB register captures all `MEMtoWB_*` inputs on each edge.
- Priority: `rst` low > `flush` > `stall` > normal capture.
  - `flush`: clear the valid bit; leave the data fields don't-care.
  - `stall`: hold every field.
- Commit value selection:
  - `Link`: PC+8, modulo 2^32.
  - Otherwise `MemtoReg`: aligned load data.
  - Otherwise: ALU result.
- Load alignment is big-endian; offset `off` = ALUResult[1:0].
  - LB/LBU: byte at bits [31-8·off : 24-8·off], sign- or zero-extended.
  - LH/LHU: off[1]=0 selects [31:16], off[1]=1 selects [15:0]; sign- or zero-extended; off[0] is ignored.
  - LW: full word.
- `RegWrite` = valid & RegWrite field & (`writeReg` ≠ 0). Register $0 is never written.
- `writeReg`/`writeData` are combinational from the WB register; they are don't-care when `RegWrite` = 0.
- Forward holding register updates every edge:
  - `fwd_valid` takes current `RegWrite`.
  - `fwd_reg`/`fwd_data` take the current write values.
  - It is not frozen by `stall`: a stalled valid writing instruction re-asserts the same write, which is idempotent.
- `retired` increments by 1 on each edge where the WB slot is valid and `stall` = 0. It wraps modulo 2^CNT_W.

## Timing
- Latency: MEM inputs to register-file write port is one cycle. The write lands in the register file on the following edge.
- Forward outputs lag `RegWrite` by exactly one cycle.
- Reset values: valid = 0, `RegWrite` = 0, `writeReg` = 0, `writeData` = 0, `fwd_valid` = 0, `fwd_reg` = 0, `fwd_data` = 0, `retired` = 0.
- Reset mid-stream drops the in-flight instruction with no write. `retired` does not count it.
- `flush` and `stall` asserted together: flush wins, and the slot becomes a bubble next cycle.
- Stalled valid instruction: `RegWrite` stays asserted each stalled cycle; `retired` counts it once, on the unstalled edge.
- Write to $0 yields `RegWrite` = 0, but the instruction still counts as retired.
- No combinational path from any input to any output; every output is a flop or logic on flops.

## Structure
- Shared package `mips_pkg`:
  - LoadType constants: LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011, LBU = 3'b100. Codes 3'b101–3'b111 behave as LW.
  - Constant `REG_ZERO` = 5'd0.
- One natural sub-module: `load_align`, purely combinational, with inputs word, offset and LoadType and a 32-bit aligned result.
- Top level contains the WB register, commit mux, forward register and counter.

## Test plan
- Reset with `rst` = 0 held 2 cycles while inputs toggle -> all outputs 0; `retired` = 0.
- ALU write: valid, WriteReg = 8, ALUResult = 0x0000_1234 -> next cycle `RegWrite` = 1, `writeReg` = 8, `writeData` = 0x0000_1234; following cycle `fwd_valid` = 1, `fwd_reg` = 8, `fwd_data` = 0x0000_1234.
- Loads from MemData = 0x80FF_7F01:
  - LB off = 0 -> 0xFFFF_FF80.
  - LBU off = 1 -> 0x0000_00FF.
  - LB off = 2 -> 0x0000_007F.
  - LH off = 2 -> 0x0000_7F01.
  - LHU off = 0 -> 0x0000_80FF.
- Link: PC = 0xFFFF_FFFC, WriteReg = 31 -> `writeData` = 0x0000_0004. Write to $0 -> `RegWrite` = 0 and `retired` still increments.
- Stall 3 cycles with a valid write, then release -> `RegWrite` high for 4 cycles; `retired` +1 total. `flush` & `stall` together -> bubble, `RegWrite` = 0.
- Counter wrap with `CNT_W` = 4: 17 valid unstalled instructions -> `retired` = 1.
